// File: rtl/fcore_program_loader.sv
// fcore_program_loader: packs a 16-bit instruction stream into 2*INSTRUCTION_WIDTH
// program-memory words, pairing each LDC instruction with the constant that follows it.

package fcore_isa;
    localparam int unsigned OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] LDC = 5'h0C;
endpackage

module fcore_program_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned OPCODE_WIDTH      = 5,
    parameter int unsigned PROGRAM_DEPTH     = 4096
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [INSTRUCTION_WIDTH-1:0]        data_in,
    input  logic                                valid_in,
    input  logic                                last_in,
    output logic                                ready_out,
    output logic                                mem_we,
    output logic [$clog2(PROGRAM_DEPTH)-1:0]    mem_addr,
    output logic [2*INSTRUCTION_WIDTH-1:0]      mem_data,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [$clog2(PROGRAM_DEPTH):0]      program_length
);

    localparam int unsigned IW = INSTRUCTION_WIDTH;
    localparam int unsigned DW = 2 * INSTRUCTION_WIDTH;
    localparam int unsigned AW = $clog2(PROGRAM_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, CONST, ERROR} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [IW-1:0]   hold_q,  hold_d;
    logic            we_q,    we_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   data_q,  data_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;
    logic [CW-1:0]   len_q,   len_d;
    logic            ready_q, ready_d;
    logic            busy_q,  busy_d;

    logic            accept;
    logic            is_ldc;
    logic            full;
    logic            wr_req;
    logic [DW-1:0]   wr_data;

    assign accept = valid_in & ready_q;
    assign is_ldc = (data_in[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(fcore_isa::LDC));
    assign full   = (cnt_q == CW'(PROGRAM_DEPTH));

    // Next-state and registered-output logic for the loader FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        len_d   = len_q;
        wr_req  = 1'b0;
        wr_data = '0;

        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (is_ldc) begin
                        hold_d = data_in;
                        if (last_in) begin
                            // A program cannot end on an unpaired LDC.
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end else begin
                            state_d = CONST;
                        end
                    end else begin
                        wr_req  = 1'b1;
                        wr_data = {IW'(0), data_in};
                    end
                end
            end
            CONST: begin
                // The constant is pure data; its opcode bits are not decoded.
                if (accept) begin
                    wr_req  = 1'b1;
                    wr_data = {data_in, hold_q};
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_req) begin
            if (full) begin
                err_d   = 1'b1;
                state_d = ERROR;
            end else begin
                we_d   = 1'b1;
                addr_d = cnt_q[AW-1:0];
                data_d = wr_data;
                cnt_d  = cnt_q + CW'(1);
                if (last_in) begin
                    len_d   = cnt_q + CW'(1);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
        end
    end

    assign ready_d = (state_d == LOAD) || (state_d == CONST);
    assign busy_d  = ready_d;

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            len_q   <= len_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_out      = ready_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_data       = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign program_length = len_q;

endmodule

// File: tb/tb_fcore_program_loader.sv
// Directed bench for fcore_program_loader: vector table plus multi-cycle sequences.

module tb_fcore_program_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic        valid_in;
    logic        last_in;

    logic        ready_out, mem_we, busy, done, error;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic [12:0] program_length;

    logic        r4_ready, m4_we, b4_busy, d4_done, e4_error;
    logic [1:0]  m4_addr;
    logic [31:0] m4_data;
    logic [2:0]  l4_len;

    int checks   = 0;
    int failures = 0;

    fcore_program_loader dut (
        .clock(clk), .reset(rst_n), .start(start), .data_in(data_in),
        .valid_in(valid_in), .last_in(last_in), .ready_out(ready_out),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .error(error), .program_length(program_length)
    );

    fcore_program_loader #(.PROGRAM_DEPTH(4)) dut4 (
        .clock(clk), .reset(rst_n), .start(start), .data_in(data_in),
        .valid_in(valid_in), .last_in(last_in), .ready_out(r4_ready),
        .mem_we(m4_we), .mem_addr(m4_addr), .mem_data(m4_data),
        .busy(b4_busy), .done(d4_done), .error(e4_error), .program_length(l4_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [15:0] data;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_err;
        logic        exp_ready;
        logic [12:0] exp_len;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; valid_in = 1'b0; last_in = 1'b0; data_in = '0;
    endtask

    vec_t vt[16];
    logic [15:0] prog[10];
    logic [31:0] exp_wr[7];
    int widx;
    int idx;
    int cyc;
    logic saw_done;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step(); step();

        // Reset state
        chk("rst_ready", 64'(ready_out), 64'd0);
        chk("rst_we",    64'(mem_we),    64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(error),     64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_data",  64'(mem_data),  64'd0);
        chk("rst_len",   64'(program_length), 64'd0);
        rst_n = 1'b1;
        step();

        // start, valid, last, data, we, addr, data, done, err, ready, len
        vt[0]  = '{1,0,0,16'h0000, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[1]  = '{0,1,0,16'h0041, 1,12'd0,32'h00000041,  0,0,1,13'd0};
        vt[2]  = '{0,1,0,16'h0082, 1,12'd1,32'h00000082,  0,0,1,13'd0};
        vt[3]  = '{0,1,1,16'h00C3, 1,12'd2,32'h000000C3,  1,0,0,13'd3};
        vt[4]  = '{1,0,0,16'h0000, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[5]  = '{0,1,0,16'h100C, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[6]  = '{0,1,1,16'hBEEF, 1,12'd0,32'hBEEF100C,  1,0,0,13'd1};
        vt[7]  = '{1,0,0,16'h0000, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[8]  = '{0,1,0,16'h002C, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[9]  = '{0,1,0,16'h000C, 1,12'd0,32'h000C002C,  0,0,1,13'd0};
        vt[10] = '{0,1,1,16'h0041, 1,12'd1,32'h00000041,  1,0,0,13'd2};
        vt[11] = '{0,1,0,16'h0041, 0,12'd0,32'h0,         0,0,0,13'd2};
        vt[12] = '{1,0,0,16'h0000, 0,12'd0,32'h0,         0,0,1,13'd0};
        vt[13] = '{0,1,1,16'h00AC, 0,12'd0,32'h0,         0,1,0,13'd0};
        vt[14] = '{0,1,0,16'h0041, 0,12'd0,32'h0,         0,1,0,13'd0};
        vt[15] = '{1,0,0,16'h0000, 0,12'd0,32'h0,         0,0,1,13'd0};

        for (int i = 0; i < 16; i++) begin
            start = vt[i].start; valid_in = vt[i].valid;
            last_in = vt[i].last; data_in = vt[i].data;
            step();
            chk($sformatf("v%0d_we", i),    64'(mem_we),    64'(vt[i].exp_we));
            if (vt[i].exp_we) begin
                chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vt[i].exp_addr));
                chk($sformatf("v%0d_data", i), 64'(mem_data), 64'(vt[i].exp_data));
            end
            chk($sformatf("v%0d_done", i),  64'(done),      64'(vt[i].exp_done));
            chk($sformatf("v%0d_err", i),   64'(error),     64'(vt[i].exp_err));
            chk($sformatf("v%0d_ready", i), 64'(ready_out), 64'(vt[i].exp_ready));
            chk($sformatf("v%0d_busy", i),  64'(busy),      64'(vt[i].exp_ready));
            chk($sformatf("v%0d_len", i),   64'(program_length), 64'(vt[i].exp_len));
        end
        // Finish the load opened by the last vector
        idle_inputs();
        valid_in = 1'b1; last_in = 1'b1; data_in = 16'h0041;
        step();
        chk("tail_we", 64'(mem_we), 64'd1);
        chk("tail_done", 64'(done), 64'd1);
        chk("tail_len", 64'(program_length), 64'd1);
        idle_inputs();
        step();

        // Mixed program with randomly gapped valid_in
        prog = '{16'h0041, 16'h100C, 16'h1234, 16'h0082, 16'h002C,
                 16'h000C, 16'h00C3, 16'h0044, 16'h00AC, 16'hBEEF};
        exp_wr = '{32'h00000041, 32'h1234100C, 32'h00000082, 32'h000C002C,
                   32'h000000C3, 32'h00000044, 32'hBEEF00AC};
        start = 1'b1;
        step();
        start = 1'b0;
        idx = 0; widx = 0; cyc = 0; saw_done = 1'b0;
        while (idx < 10 && cyc < 200) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = prog[idx];
            last_in  = (idx == 9);
            step();
            cyc++;
            if (valid_in) idx++;
            if (mem_we) begin
                if (widx < 7) begin
                    chk($sformatf("rnd_addr%0d", widx), 64'(mem_addr), 64'(widx));
                    chk($sformatf("rnd_data%0d", widx), 64'(mem_data), 64'(exp_wr[widx]));
                end
                widx++;
            end
            if (done) saw_done = 1'b1;
        end
        idle_inputs();
        chk("rnd_timeout", 64'(idx), 64'd10);
        chk("rnd_wcount", 64'(widx), 64'd7);
        chk("rnd_done", 64'(saw_done), 64'd1);
        chk("rnd_len", 64'(program_length), 64'd7);
        step();

        // Reset asserted mid-load
        start = 1'b1;
        step();
        start = 1'b0; valid_in = 1'b1;
        data_in = 16'h0041; step();
        data_in = 16'h0082; step();
        data_in = 16'h100C; step();
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready_out), 64'd0);
        chk("mid_rst_busy",  64'(busy),      64'd0);
        chk("mid_rst_we",    64'(mem_we),    64'd0);
        chk("mid_rst_addr",  64'(mem_addr),  64'd0);
        chk("mid_rst_data",  64'(mem_data),  64'd0);
        chk("mid_rst_len",   64'(program_length), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; step();
        start = 1'b0;
        valid_in = 1'b1; last_in = 1'b1; data_in = 16'h00C3;
        step();
        chk("post_rst_we",   64'(mem_we),   64'd1);
        chk("post_rst_addr", 64'(mem_addr), 64'd0);
        chk("post_rst_data", 64'(mem_data), 64'h000000C3);
        chk("post_rst_done", 64'(done),     64'd1);
        chk("post_rst_len",  64'(program_length), 64'd1);
        idle_inputs();
        step();

        // Overflow on a 4-deep program memory
        start = 1'b1; step();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            last_in  = (i == 4);
            data_in  = 16'h0041 + 16'(i);
            step();
            if (d4_done) saw_done = 1'b1;
            if (i < 4) begin
                chk($sformatf("ovf_we%0d", i),   64'(m4_we),   64'd1);
                chk($sformatf("ovf_addr%0d", i), 64'(m4_addr), 64'(i));
                chk($sformatf("ovf_data%0d", i), 64'(m4_data), 64'(32'h00000041 + 32'(i)));
            end else begin
                chk("ovf_we4",    64'(m4_we),    64'd0);
                chk("ovf_err",    64'(e4_error), 64'd1);
                chk("ovf_ready",  64'(r4_ready), 64'd0);
                chk("ovf_busy",   64'(b4_busy),  64'd0);
                chk("big_done",   64'(done),     64'd1);
                chk("big_len",    64'(program_length), 64'd5);
            end
        end
        idle_inputs();
        step();
        chk("ovf_no_done", 64'(saw_done | d4_done), 64'd0);
        chk("ovf_err_hold", 64'(e4_error), 64'd1);
        start = 1'b1; step();
        start = 1'b0;
        chk("ovf_err_clear", 64'(e4_error), 64'd0);
        chk("ovf_restart_ready", 64'(r4_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
